// File: rtl/hamming_word_gen.sv
// Serial Hamming-distance word generator: flips exactly min(d, WIDTH) bits of a
// captured word, one bit position per clock, with positions chosen by a Galois LFSR.
`timescale 1ns/1ps
module hamming_word_gen #(
  parameter int          WIDTH     = 32,
  parameter int          CNT_W     = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [CNT_W-1:0] dist_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] W_C    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_I = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [15:0]      lfsr;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] flips_left;

  logic [CNT_W-1:0] bits_left;
  logic             flip;
  logic [WIDTH-1:0] flip_mask;
  logic [WIDTH-1:0] work_nxt;

  function automatic logic [CNT_W-1:0] sat_dist(input logic [CNT_W-1:0] d);
    return (d > W_C) ? W_C : d;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Forced flip once the remaining quota equals the remaining bits, so the
  // total flip count always lands exactly on the target.
  always_comb begin
    bits_left = W_C - counter;
    flip      = (flips_left != '0) && ((flips_left == bits_left) || lfsr[0]);
    flip_mask = flip ? (WIDTH'(1) << counter) : '0;
    work_nxt  = (work & ~flip_mask) | (~src & flip_mask);
  end

  // Control: FSM, bit index, LFSR and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      lfsr    <= LFSR_SEED;
      out_o   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            counter <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          lfsr <= lfsr_step(lfsr);
          if (counter == LAST_I) begin
            out_o <= work_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: captured word, working copy and remaining flip quota
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      src        <= in1;
      work       <= in1;
      flips_left <= sat_dist(dist_i);
    end else if (state == RUN) begin
      work <= work_nxt;
      if (flip) flips_left <= flips_left - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_word_gen.sv
// Randomized self-checking bench for hamming_word_gen against a behavioural model.
`timescale 1ns/1ps
module tb_hamming_word_gen;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam logic [15:0] SEED = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] in1 = '0;
  logic [CNT_W-1:0] dist_i = '0;
  logic [WIDTH-1:0] out_o;
  logic             busy;
  logic             done;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;

  hamming_word_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .dist_i(dist_i),
    .out_o(out_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: walk the word LSB first, spending the flip quota on LFSR
  // coin tosses and forcing flips when quota equals the bits still ahead.
  task automatic model_run(input logic [31:0] w, input int d, output logic [31:0] r);
    int left;
    bit f;
    left = (d > WIDTH) ? WIDTH : d;
    r = w;
    for (int i = 0; i < WIDTH; i++) begin
      f = (left != 0) && ((left == WIDTH - i) || m_lfsr[0]);
      if (f) begin
        r[i] = ~w[i];
        left--;
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  task automatic run_op(input logic [31:0] w, input int d, input bit poke_run, input bit poke_done);
    logic [31:0] exp;
    int cyc, bc, want;
    @(negedge clk);
    in1 = w;
    dist_i = CNT_W'(d);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_run(w, d, exp);
    in1 = $urandom;
    dist_i = CNT_W'($urandom);
    cyc = 0;
    bc = 0;
    while (!done && cyc < 100) begin
      if (busy) bc++;
      if (poke_run && cyc == 10) start = 1'b1;
      else if (poke_run && cyc == 11) start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    want = (d > WIDTH) ? WIDTH : d;
    check("latency", 32'(cyc), 32'd32);
    check("busy_cycles", 32'(bc), 32'd32);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    check("out_model", out_o, exp);
    check("popcount", 32'($countones(out_o ^ w)), 32'(want));
    if (poke_done) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_pulse", {31'b0, done}, 32'd0);
    if (poke_done) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        check("ignored_done", {31'b0, done}, 32'd0);
        check("ignored_busy", {31'b0, busy}, 32'd0);
      end
      check("hold_out", out_o, exp);
    end
  endtask

  initial begin
    logic [31:0] w;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out_o, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    m_lfsr = SEED;

    run_op(32'h0000_0000, 3, 1'b0, 1'b0);
    run_op(32'hA5A5_A5A5, 0, 1'b0, 1'b0);
    check("d0_identity", out_o, 32'hA5A5_A5A5);
    run_op(32'hA5A5_A5A5, 32, 1'b0, 1'b0);
    check("d32_invert", out_o, 32'h5A5A_5A5A);
    run_op(32'hA5A5_A5A5, 40, 1'b0, 1'b0);
    check("d40_saturate", out_o, 32'h5A5A_5A5A);
    run_op(32'h1234_5678, 5, 1'b1, 1'b1);

    for (int k = 0; k < 200; k++) run_op($urandom, 7, 1'b0, 1'b0);
    for (int k = 0; k < 200; k++) run_op($urandom, 1, 1'b0, 1'b0);
    for (int k = 0; k < 200; k++) run_op($urandom, 31, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) run_op($urandom, int'($urandom_range(0, 63)), 1'b0, 1'b0);

    // Abort an operation while bit 15 is pending
    @(negedge clk);
    in1 = $urandom;
    dist_i = 6'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_out", out_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_lfsr = SEED;
    w = 32'hFFFF_FFFF;
    run_op(w, 4, 1'b0, 1'b0);
    check("post_abort_pop", 32'($countones(~out_o)), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
